// File: rtl/demo_sequencer.sv
// Control-word sequencer: steps a loadable program table into the ALU datapath by button or timer.
// Optional 7-segment step display enabled by defining DEMO_SEQ_SEG_EN.
module demo_sequencer #(
  parameter int unsigned INST_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned RUN_DIV  = 16,
  localparam int unsigned IDX_W   = $clog2(DEPTH),
  localparam int unsigned CW      = INST_W + ADDR_W + 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_n,
  input  logic              run_mode,
  input  logic              loop_en,
  input  logic [IDX_W:0]    prog_len,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [CW-1:0]     prog_data,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [4:0]        alu_cont,
  output logic [1:0]        alu_b_src,
  output logic              alu_a_src,
  output logic              reg_write,
  output logic              reg_write_src,
  output logic              dest_reg,
  output logic              mem_we,
  output logic [IDX_W-1:0]  step_idx,
  output logic              busy,
  output logic              done,
  output logic [6:0]        seg_n
);

  localparam int unsigned ALU_LSB   = INST_W;
  localparam int unsigned BSRC_LSB  = INST_W + 5;
  localparam int unsigned ASRC_BIT  = INST_W + 7;
  localparam int unsigned RW_BIT    = INST_W + 8;
  localparam int unsigned DEST_BIT  = INST_W + 9;
  localparam int unsigned RWS_BIT   = INST_W + 10;
  localparam int unsigned MADDR_LSB = INST_W + 11;
  localparam int unsigned MWE_BIT   = CW - 1;
  localparam int unsigned DB_W      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned DIV_W     = $clog2(RUN_DIV);
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_HOLD, ST_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_table [DEPTH];
  logic [CW-1:0]     r_word;
  logic [IDX_W-1:0]  r_step_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_btn_s1;
  logic              r_btn_s2;
  logic              r_btn_db;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_btn_step;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_run_step;

  logic              w_step;
  logic [IDX_W:0]    w_len;
  logic              w_more;
  logic [IDX_W-1:0]  w_inc;
  logic [IDX_W-1:0]  w_load_idx;
  logic [CW-1:0]     w_load_word;

  // Button: two-flop synchroniser, then accept a new level after DEBOUNCE differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_s1   <= 1'b1;
      r_btn_s2   <= 1'b1;
      r_btn_db   <= 1'b1;
      r_db_cnt   <= '0;
      r_btn_step <= 1'b0;
    end else begin
      r_btn_s1   <= btn_n;
      r_btn_s2   <= r_btn_s1;
      r_btn_step <= 1'b0;
      if (r_btn_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE - 1)) begin
        r_db_cnt   <= '0;
        r_btn_db   <= r_btn_s2;
        r_btn_step <= ~r_btn_s2;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Run-mode divider: one step pulse every RUN_DIV cycles, held cleared in button mode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt  <= '0;
      r_run_step <= 1'b0;
    end else if (!run_mode) begin
      r_div_cnt  <= '0;
      r_run_step <= 1'b0;
    end else if (r_div_cnt == DIV_W'(RUN_DIV - 1)) begin
      r_div_cnt  <= '0;
      r_run_step <= 1'b1;
    end else begin
      r_div_cnt  <= r_div_cnt + DIV_W'(1);
      r_run_step <= 1'b0;
    end
  end

  assign w_step      = run_mode ? r_run_step : r_btn_step;
  assign w_len       = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign w_inc       = r_step_idx + IDX_W'(1);
  assign w_more      = ({1'b0, r_step_idx} + (IDX_W+1)'(1)) < w_len;
  assign w_load_idx  = (r_state == ST_HOLD && w_more) ? w_inc : '0;
  assign w_load_word = r_table[w_load_idx];

  // Program table has no reset; writes only land while the sequencer is parked
  always_ff @(posedge clk) begin
    if (prog_we && (r_state == ST_IDLE || r_state == ST_DONE)) begin
      r_table[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_word     <= '0;
      r_step_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_step && w_len != '0) begin
            r_state    <= ST_EXEC;
            r_step_idx <= '0;
            r_word     <= w_load_word;
            r_busy     <= 1'b1;
          end
        end
        ST_EXEC: begin
          // Write enables pulse for the EXEC cycle only
          r_state          <= ST_HOLD;
          r_word[RW_BIT]   <= 1'b0;
          r_word[MWE_BIT]  <= 1'b0;
        end
        ST_HOLD: begin
          if (w_step) begin
            if (w_more || loop_en) begin
              r_state    <= ST_EXEC;
              r_step_idx <= w_load_idx;
              r_word     <= w_load_word;
            end else begin
              r_state <= ST_DONE;
              r_word  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (w_step) begin
            r_state    <= ST_IDLE;
            r_step_idx <= '0;
            r_done     <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign inst          = r_word[INST_W-1:0];
  assign alu_cont      = r_word[ALU_LSB +: 5];
  assign alu_b_src     = r_word[BSRC_LSB +: 2];
  assign alu_a_src     = r_word[ASRC_BIT];
  assign reg_write     = r_word[RW_BIT];
  assign dest_reg      = r_word[DEST_BIT];
  assign reg_write_src = r_word[RWS_BIT];
  assign mem_addr      = r_word[MADDR_LSB +: ADDR_W];
  assign mem_we        = r_word[MWE_BIT];
  assign step_idx      = r_step_idx;
  assign busy          = r_busy;
  assign done          = r_done;

`ifdef DEMO_SEQ_SEG_EN
  logic [3:0] w_nib;
  logic [6:0] w_seg;
  logic [6:0] r_seg;

  assign w_nib = 4'(r_step_idx);

  // Hex glyphs, segment order gfedcba, active-low
  always_comb begin
    w_seg = 7'b1111111;
    case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_seg <= 7'b1000000;
    else        r_seg <= w_seg;
  end

  assign seg_n = r_seg;
`else
  assign seg_n = 7'b1111111;
`endif

endmodule
